// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer: green/yellow/all-red cycling on the 1 Hz tick,
// pedestrian green shortening and emergency-vehicle preemption.
module traffic_phase_scheduler #(
    parameter int GREEN_T  = 30,
    parameter int YEL_T    = 3,
    parameter int ALLRED_T = 2,
    parameter int SHORT_T  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req_a,
    input  logic       ped_req_b,
    input  logic       emerg_a,
    input  logic       emerg_b,
    output logic [3:0] A_lights,
    output logic [3:0] B_lights,
    output logic [3:0] Astate,
    output logic [3:0] Bstate,
    output logic [6:0] Acountdown,
    output logic [6:0] Bcountdown,
    output logic       emerg_active
);

    typedef enum logic [2:0] {A_GO, A_YEL, AR_A, B_GO, B_YEL, AR_B} state_t;

    localparam logic [6:0] GREEN_C  = 7'(GREEN_T);
    localparam logic [6:0] YEL_C    = 7'(YEL_T);
    localparam logic [6:0] ALLRED_C = 7'(ALLRED_T);
    localparam logic [6:0] SHORT_C  = 7'(SHORT_T);

    state_t     state;
    logic [6:0] cnt;
    logic       pa, pb;
    logic       a_side, eff_a, eff_b;
    logic       hold, shorten, enter_ar_a, enter_ar_b;

    function automatic state_t next_phase(input state_t s);
        case (s)
            A_GO:    return A_YEL;
            A_YEL:   return AR_A;
            AR_A:    return B_GO;
            B_GO:    return B_YEL;
            B_YEL:   return AR_B;
            default: return A_GO;
        endcase
    endfunction

    function automatic logic [6:0] phase_len(input state_t s);
        case (s)
            A_GO, B_GO:   return GREEN_C;
            A_YEL, B_YEL: return YEL_C;
            default:      return ALLRED_C;
        endcase
    endfunction

    // When both roads call for preemption, the road showing green/yellow keeps it;
    // during all-red road A is served first.
    assign a_side = (state == A_GO) || (state == A_YEL) || (state == AR_A) || (state == AR_B);
    assign eff_a  = emerg_a && (!emerg_b || a_side);
    assign eff_b  = emerg_b && (!emerg_a || !a_side);

    assign hold    = ((state == A_GO) && eff_a) || ((state == B_GO) && eff_b);
    assign shorten = (cnt > SHORT_C) &&
                     (((state == A_GO) && (pa || ped_req_a)) ||
                      ((state == B_GO) && (pb || ped_req_b)));

    // Yellow phases are never cut or frozen, so they only advance on a terminal tick.
    assign enter_ar_a = (state == A_YEL) && tick && (cnt <= 7'd1);
    assign enter_ar_b = (state == B_YEL) && tick && (cnt <= 7'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= AR_B;
            cnt          <= ALLRED_C;
            pa           <= 1'b0;
            pb           <= 1'b0;
            emerg_active <= 1'b0;
        end else begin
            emerg_active <= emerg_a | emerg_b;
            pa           <= ped_req_a || (pa && !enter_ar_a);
            pb           <= ped_req_b || (pb && !enter_ar_b);

            if ((state == B_GO) && eff_a) begin
                state <= B_YEL;
                cnt   <= YEL_C;
            end else if ((state == A_GO) && eff_b) begin
                state <= A_YEL;
                cnt   <= YEL_C;
            end else if (!hold) begin
                if (shorten) begin
                    cnt <= SHORT_C;
                end else if (tick) begin
                    if (cnt > 7'd1) begin
                        cnt <= cnt - 7'd1;
                    end else begin
                        state <= next_phase(state);
                        cnt   <= phase_len(next_phase(state));
                    end
                end
            end
        end
    end

    // Lamp word is {walk, green, yellow, red}; countdowns are nominal times to the next colour change.
    always_comb begin
        A_lights   = 4'b0001;
        B_lights   = 4'b0001;
        Astate     = 4'd0;
        Bstate     = 4'd0;
        Acountdown = cnt;
        Bcountdown = cnt;
        case (state)
            A_GO: begin
                A_lights   = 4'b0100;
                B_lights   = 4'b1001;
                Astate     = 4'd1;
                Bcountdown = cnt + YEL_C + ALLRED_C;
            end
            A_YEL: begin
                A_lights   = 4'b0010;
                Astate     = 4'd2;
                Bcountdown = cnt + ALLRED_C;
            end
            AR_A: begin
                Acountdown = cnt + GREEN_C + YEL_C + ALLRED_C;
            end
            B_GO: begin
                A_lights   = 4'b1001;
                B_lights   = 4'b0100;
                Bstate     = 4'd1;
                Acountdown = cnt + YEL_C + ALLRED_C;
            end
            B_YEL: begin
                B_lights   = 4'b0010;
                Bstate     = 4'd2;
                Acountdown = cnt + ALLRED_C;
            end
            default: begin
                Bcountdown = cnt + GREEN_C + YEL_C + ALLRED_C;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: explicit vector table, hand-written preemption and
// pedestrian sequences, and randomized traffic against a phase-walking reference model.
module tb_traffic_phase_scheduler;

    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int S  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, ped_req_a, ped_req_b, emerg_a, emerg_b;
    logic [3:0] A_lights, B_lights, Astate, Bstate;
    logic [6:0] Acountdown, Bcountdown;
    logic       emerg_active;

    traffic_phase_scheduler #(
        .GREEN_T(G), .YEL_T(Y), .ALLRED_T(AR), .SHORT_T(S)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
        .emerg_a(emerg_a), .emerg_b(emerg_b),
        .A_lights(A_lights), .B_lights(B_lights),
        .Astate(Astate), .Bstate(Bstate),
        .Acountdown(Acountdown), .Bcountdown(Bcountdown),
        .emerg_active(emerg_active)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase index 0..5 = A green, A yellow, all-red, B green, B yellow, all-red.
    int dur[6] = '{G, Y, AR, G, Y, AR};
    int m_ph, m_rem;
    bit m_pa, m_pb, m_emg;

    // Colour of road r in phase ph: 0 red, 1 green, 2 yellow.
    function automatic int colour(input int ph, input int r);
        if (ph / 3 != r) return 0;
        if (ph % 3 == 0) return 1;
        if (ph % 3 == 1) return 2;
        return 0;
    endfunction

    function automatic int model_cd(input int r);
        int total = m_rem;
        int p = (m_ph + 1) % 6;
        int c0 = colour(m_ph, r);
        while (colour(p, r) == c0) begin
            total += dur[p];
            p = (p + 1) % 6;
        end
        return total;
    endfunction

    function automatic logic [3:0] model_lamps(input int r);
        int c = colour(m_ph, r);
        return {m_ph == (1 - r) * 3, c == 1, c == 2, c == 0};
    endfunction

    task automatic model_reset();
        m_ph = 5; m_rem = AR; m_pa = 0; m_pb = 0; m_emg = 0;
    endtask

    task automatic model_step(input bit t, input bit pra, input bit prb, input bit ea, input bit eb);
        int x;
        int old_ph = m_ph;
        int lit = (m_ph % 3 != 2) ? m_ph / 3 : -1;
        if (ea && eb)  x = (lit >= 0) ? lit : 0;
        else if (ea)   x = 0;
        else if (eb)   x = 1;
        else           x = -1;
        if (x >= 0 && m_ph == (1 - x) * 3) begin
            m_ph  = m_ph + 1;
            m_rem = Y;
        end else if (x >= 0 && m_ph == x * 3) begin
            m_rem = m_rem;
        end else if (m_ph % 3 == 0 && ((m_ph == 0) ? (m_pa || pra) : (m_pb || prb)) && m_rem > S) begin
            m_rem = S;
        end else if (t) begin
            if (m_rem > 1) m_rem--;
            else begin
                m_ph  = (m_ph + 1) % 6;
                m_rem = dur[m_ph];
            end
        end
        m_pa  = pra || (m_pa && !(m_ph == 2 && old_ph != 2));
        m_pb  = prb || (m_pb && !(m_ph == 5 && old_ph != 5));
        m_emg = ea || eb;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " A_lights"}, int'(A_lights), int'(model_lamps(0)));
        chk({tag, " B_lights"}, int'(B_lights), int'(model_lamps(1)));
        chk({tag, " Astate"}, int'(Astate), colour(m_ph, 0));
        chk({tag, " Bstate"}, int'(Bstate), colour(m_ph, 1));
        chk({tag, " Acountdown"}, int'(Acountdown), model_cd(0));
        chk({tag, " Bcountdown"}, int'(Bcountdown), model_cd(1));
        chk({tag, " emerg_active"}, int'(emerg_active), int'(m_emg));
    endtask

    // Called on a negedge: apply inputs, clock once, return on the following negedge.
    task automatic drive(input bit t, input bit pra, input bit prb, input bit ea, input bit eb);
        tick = t; ped_req_a = pra; ped_req_b = prb; emerg_a = ea; emerg_b = eb;
        @(posedge clk);
        model_step(t, pra, prb, ea, eb);
        @(negedge clk);
        tick = 0; ped_req_a = 0; ped_req_b = 0;
    endtask

    typedef struct {
        logic       t, pra, prb, ea, eb;
        logic [3:0] al, bl;
        int         acd, bcd;
        logic       emg;
    } vec_t;

    vec_t vt[18];

    bit ea_r, eb_r;
    int guard;

    initial begin
        // Hand-derived walk from reset (state all-red after B, one tick left).
        vt[0]  = '{0,0,0,0,0, 4'b0001, 4'b0001, 1, 9, 0};
        vt[1]  = '{1,0,0,0,0, 4'b0100, 4'b1001, 5, 8, 0};
        vt[2]  = '{1,0,0,0,0, 4'b0100, 4'b1001, 4, 7, 0};
        vt[3]  = '{0,1,0,0,0, 4'b0100, 4'b1001, 2, 5, 0};
        vt[4]  = '{1,0,0,0,0, 4'b0100, 4'b1001, 1, 4, 0};
        vt[5]  = '{1,0,0,0,0, 4'b0010, 4'b0001, 2, 3, 0};
        vt[6]  = '{1,0,0,0,0, 4'b0010, 4'b0001, 1, 2, 0};
        vt[7]  = '{1,0,0,0,0, 4'b0001, 4'b0001, 9, 1, 0};
        vt[8]  = '{1,0,0,0,0, 4'b1001, 4'b0100, 8, 5, 0};
        vt[9]  = '{0,0,0,1,0, 4'b0001, 4'b0010, 3, 2, 1};
        vt[10] = '{1,0,0,1,0, 4'b0001, 4'b0010, 2, 1, 1};
        vt[11] = '{1,0,0,1,0, 4'b0001, 4'b0001, 1, 9, 1};
        vt[12] = '{1,0,0,1,0, 4'b0100, 4'b1001, 5, 8, 1};
        vt[13] = '{1,0,0,1,0, 4'b0100, 4'b1001, 5, 8, 1};
        vt[14] = '{1,1,0,1,0, 4'b0100, 4'b1001, 5, 8, 1};
        vt[15] = '{1,0,0,0,0, 4'b0100, 4'b1001, 2, 5, 0};
        vt[16] = '{1,0,0,0,0, 4'b0100, 4'b1001, 1, 4, 0};
        vt[17] = '{1,0,0,0,0, 4'b0010, 4'b0001, 2, 3, 0};

        rst = 0; tick = 0; ped_req_a = 0; ped_req_b = 0; emerg_a = 0; emerg_b = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("por");
        rst = 1;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_model("pre_reset_a_go");

        // Asynchronous reset in the middle of A green.
        #2 rst = 0;
        #1;
        model_reset();
        chk("async_rst A_lights", int'(A_lights), 4'b0001);
        chk("async_rst B_lights", int'(B_lights), 4'b0001);
        chk("async_rst Acountdown", int'(Acountdown), 1);
        chk("async_rst Bcountdown", int'(Bcountdown), 9);
        chk("async_rst Astate", int'(Astate), 0);
        chk("async_rst emerg_active", int'(emerg_active), 0);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].t, vt[i].pra, vt[i].prb, vt[i].ea, vt[i].eb);
            chk($sformatf("vec%0d A_lights", i), int'(A_lights), int'(vt[i].al));
            chk($sformatf("vec%0d B_lights", i), int'(B_lights), int'(vt[i].bl));
            chk($sformatf("vec%0d Acountdown", i), int'(Acountdown), vt[i].acd);
            chk($sformatf("vec%0d Bcountdown", i), int'(Bcountdown), vt[i].bcd);
            chk($sformatf("vec%0d emerg_active", i), int'(emerg_active), int'(vt[i].emg));
        end

        // Pedestrian request landing on the same clock as a tick at the start of A green.
        guard = 0;
        while (!(m_ph == 0 && m_rem == G) && guard < 40) begin
            drive(1, 0, 0, 0, 0);
            guard++;
        end
        chk("seek_a_go_start", guard < 40, 1);
        drive(1, 1, 0, 0, 0);
        chk("ped_tick Acountdown", int'(Acountdown), S);
        check_model("ped_tick");
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("ped_tick A_yellow", int'(A_lights), 4'b0010);

        // Both emergencies from all-red-after-B: A is served and held, then B.
        guard = 0;
        while (m_ph != 5 && guard < 40) begin
            drive(1, 0, 0, 0, 0);
            guard++;
        end
        chk("seek_ar_b", guard < 40, 1);
        drive(0, 0, 0, 1, 1);
        check_model("both_emerg_ar_b");
        repeat (6) drive(1, 0, 0, 1, 1);
        chk("both_emerg A held green", int'(A_lights), 4'b0100);
        chk("both_emerg A frozen cd", int'(Acountdown), G);
        drive(1, 0, 0, 0, 1);
        chk("b_emerg cuts A", int'(A_lights), 4'b0010);
        repeat (8) drive(1, 0, 0, 0, 1);
        chk("b_emerg B held green", int'(B_lights), 4'b0100);
        chk("b_emerg B frozen cd", int'(Bcountdown), G);
        check_model("b_emerg_hold");
        drive(0, 0, 0, 0, 0);

        // Free run: two full 16-tick cycles checked every tick.
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 0);
            check_model($sformatf("free%0d", i));
        end

        // Randomized traffic against the reference model.
        ea_r = 0; eb_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ea_r = !ea_r;
            if ($urandom_range(0, 39) == 0) eb_r = !eb_r;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, ea_r, eb_r);
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
